// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory/IO stage: word width, device
// register addresses, FSM state type and the address decoder.
package lc3_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] IO_BASE   = 16'hFE00;
  localparam logic [WORD_W-1:0] ADDR_KBSR = 16'hFE00;
  localparam logic [WORD_W-1:0] ADDR_KBDR = 16'hFE02;
  localparam logic [WORD_W-1:0] ADDR_DSR  = 16'hFE04;
  localparam logic [WORD_W-1:0] ADDR_DDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DEV_RAM  = 3'd0,
    DEV_KBSR = 3'd1,
    DEV_KBDR = 3'd2,
    DEV_DSR  = 3'd3,
    DEV_DDR  = 3'd4,
    DEV_NONE = 3'd5
  } dev_t;

  // Everything below the I/O page is RAM; unmapped I/O addresses decode to DEV_NONE.
  function automatic dev_t decode_addr(input logic [WORD_W-1:0] addr);
    dev_t d;
    if (addr < IO_BASE) begin
      d = DEV_RAM;
    end else begin
      case (addr)
        ADDR_KBSR: d = DEV_KBSR;
        ADDR_KBDR: d = DEV_KBDR;
        ADDR_DSR:  d = DEV_DSR;
        ADDR_DDR:  d = DEV_DDR;
        default:   d = DEV_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/lc3_memory_io_if.sv
// Memory bus between the datapath/control store (master) and the
// memory/IO stage (slave).
interface lc3_memory_io_if;
  import lc3_pkg::*;

  logic              mio_en;
  logic              r_w;
  logic [WORD_W-1:0] mar;
  logic [WORD_W-1:0] mdr;
  logic [WORD_W-1:0] mem_data;
  logic              r_bit;

  modport master (output mio_en, output r_w, output mar, output mdr,
                  input mem_data, input r_bit);
  modport slave  (input mio_en, input r_w, input mar, input mdr,
                  output mem_data, output r_bit);
endinterface

// File: rtl/lc3_ram.sv
// Single-port word RAM with write enable and one-cycle registered read.
module lc3_ram #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          i_CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_reg;

  // Write port plus registered read of the same address (read-before-write).
  always_ff @(posedge i_CLK) begin
    if (we) mem[addr] <= wdata;
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/lc3_memory_io.sv
// LC-3 memory + memory-mapped I/O stage with wait-state FSM.
// Optional feature macro: LC3_KBD_INT_EN (writable KBSR[14] and o_KB_INT).
module lc3_memory_io
  import lc3_pkg::*;
#(
  parameter int MEM_AW      = 12,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  lc3_memory_io_if.slave      bus,
  input  logic                i_KB_VALID,
  input  logic [7:0]          i_KB_DATA,
  output logic                o_KB_ACK,
  output logic                o_DISP_VALID,
  output logic [7:0]          o_DISP_DATA,
  input  logic                i_DISP_READY,
  output logic                o_KB_INT
);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              capture, commit;
  logic              lat_we_reg;
  logic [WORD_W-1:0] lat_addr_reg, lat_data_reg;
  logic              req_we;
  logic [WORD_W-1:0] req_addr, req_data;
  dev_t              dev;
  logic              acc_wr, acc_rd, kbdr_rd, ddr_wr;
  logic [WORD_W-1:0] io_rdata, io_rdata_reg, ram_rdata;
  logic              rd_ram_reg;
  logic              kb_ready_reg, kb_ack_reg, kb_ie;
  logic [7:0]        kbdr_reg;
  logic              disp_valid_reg;
  logic [7:0]        disp_data_reg;

  // In IDLE the request is still on the bus; afterwards use the latched copy.
  assign req_we   = (state_reg == IDLE) ? bus.r_w : lat_we_reg;
  assign req_addr = (state_reg == IDLE) ? bus.mar : lat_addr_reg;
  assign req_data = (state_reg == IDLE) ? bus.mdr : lat_data_reg;
  assign dev      = decode_addr(req_addr);
  assign acc_wr   = commit & req_we;
  assign acc_rd   = commit & ~req_we;
  assign kbdr_rd  = acc_rd & (dev == DEV_KBDR);
  assign ddr_wr   = acc_wr & (dev == DEV_DDR);

  // Next-state logic: commit is the single edge that enters READY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.mio_en) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = READY;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!bus.mio_en) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = READY;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      READY: begin
        if (!bus.mio_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      lat_we_reg   <= 1'b0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
    end else if (capture) begin
      lat_we_reg   <= bus.r_w;
      lat_addr_reg <= bus.mar;
      lat_data_reg <= bus.mdr;
    end
  end

  // RAM read runs continuously on the request address, so the word is
  // registered on the very edge that enters READY.
  lc3_ram #(.AW(MEM_AW), .DW(WORD_W)) u_ram (
    .i_CLK (i_CLK),
    .we    (acc_wr & (dev == DEV_RAM)),
    .addr  (req_addr[MEM_AW-1:0]),
    .wdata (req_data),
    .rdata (ram_rdata)
  );

  // Device register read mux, sampled with pre-commit register values.
  always_comb begin
    io_rdata = '0;
    case (dev)
      DEV_KBSR: io_rdata = {kb_ready_reg, kb_ie, 14'd0};
      DEV_KBDR: io_rdata = {8'h00, kbdr_reg};
      DEV_DSR:  io_rdata = {~disp_valid_reg, 15'd0};
      DEV_DDR:  io_rdata = {8'h00, disp_data_reg};
      default:  io_rdata = '0;
    endcase
  end

  // Hold the read result for the whole READY phase.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      io_rdata_reg <= '0;
      rd_ram_reg   <= 1'b0;
    end else if (commit) begin
      io_rdata_reg <= io_rdata;
      rd_ram_reg   <= (dev == DEV_RAM);
    end
  end

  // Keyboard: a KBDR read clears ready and blocks capture on that same edge.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      kb_ready_reg <= 1'b0;
      kbdr_reg     <= '0;
      kb_ack_reg   <= 1'b0;
    end else begin
      kb_ack_reg <= 1'b0;
      if (kbdr_rd) begin
        kb_ready_reg <= 1'b0;
      end else if (i_KB_VALID && !kb_ready_reg) begin
        kbdr_reg     <= i_KB_DATA;
        kb_ready_reg <= 1'b1;
        kb_ack_reg   <= 1'b1;
      end
    end
  end

  // Display: one pending char; DDR writes while busy are dropped.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      disp_valid_reg <= 1'b0;
      disp_data_reg  <= '0;
    end else if (ddr_wr && !disp_valid_reg) begin
      disp_valid_reg <= 1'b1;
      disp_data_reg  <= req_data[7:0];
    end else if (disp_valid_reg && i_DISP_READY) begin
      disp_valid_reg <= 1'b0;
    end
  end

`ifdef LC3_KBD_INT_EN
  logic kb_ie_reg, kb_int_reg;

  // Interrupt enable is the only writable KBSR bit.
  always_ff @(posedge i_CLK) begin
    if (i_RST) kb_ie_reg <= 1'b0;
    else if (acc_wr && dev == DEV_KBSR) kb_ie_reg <= req_data[14];
  end

  // Registered interrupt request: ready and enabled.
  always_ff @(posedge i_CLK) begin
    if (i_RST) kb_int_reg <= 1'b0;
    else kb_int_reg <= kb_ready_reg & kb_ie_reg;
  end

  assign kb_ie    = kb_ie_reg;
  assign o_KB_INT = kb_int_reg;
`else
  assign kb_ie    = 1'b0;
  assign o_KB_INT = 1'b0;
`endif

  assign bus.r_bit    = (state_reg == READY);
  assign bus.mem_data = (state_reg == READY && !lat_we_reg) ?
                        (rd_ram_reg ? ram_rdata : io_rdata_reg) : '0;
  assign o_KB_ACK     = kb_ack_reg;
  assign o_DISP_VALID = disp_valid_reg;
  assign o_DISP_DATA  = disp_data_reg;
endmodule

// File: tb/tb_lc3_memory_io.sv
// Self-checking bench for lc3_memory_io: directed scenarios plus randomized
// accesses, checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_lc3_memory_io;
  import lc3_pkg::*;

  localparam int MEM_AW      = 12;
  localparam int WAIT_CYCLES = 3;
  localparam int DEPTH       = 1 << MEM_AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_valid = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ack;
  logic       disp_valid;
  logic [7:0] disp_data;
  logic       disp_ready = 1'b0;
  logic       kb_int;

  int errors = 0;
  int checks = 0;

  lc3_memory_io_if bus();

  lc3_memory_io #(.MEM_AW(MEM_AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .bus          (bus),
    .i_KB_VALID   (kb_valid),
    .i_KB_DATA    (kb_data),
    .o_KB_ACK     (kb_ack),
    .o_DISP_VALID (disp_valid),
    .o_DISP_DATA  (disp_data),
    .i_DISP_READY (disp_ready),
    .o_KB_INT     (kb_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_ready, m_we, m_rvalid;
  int          m_left;
  logic [15:0] m_addr, m_wd, m_rd;
  logic [15:0] mem [DEPTH];
  bit          mv [DEPTH];
  bit          kb_rdy, kb_ie, dv, m_ack, m_int, started;
  logic [7:0]  kb_dat, dd;

  always @(posedge clk) begin : model
    bit p_rdy, p_ie, p_dv, clr, commit;
    int idx;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_we = 0; m_rvalid = 0; m_rd = 0;
      kb_rdy = 0; kb_ie = 0; kb_dat = 0; dv = 0; dd = 0;
      m_ack = 0; m_int = 0; started = 1;
    end else begin
      p_rdy = kb_rdy; p_ie = kb_ie; p_dv = dv; clr = 0; commit = 0;
      if (!m_busy) begin
        if (bus.mio_en) begin
          m_busy = 1; m_ready = 0; m_we = bus.r_w;
          m_addr = bus.mar; m_wd = bus.mdr; m_left = WAIT_CYCLES;
          commit = (m_left == 0);
        end
      end else if (!m_ready) begin
        if (!bus.mio_en) m_busy = 0;
        else begin
          m_left--;
          commit = (m_left == 0);
        end
      end else if (!bus.mio_en) begin
        m_busy = 0; m_ready = 0;
      end
      if (commit) begin
        m_ready = 1; m_rvalid = 1; m_rd = 16'h0000;
        if (m_addr < 16'hFE00) begin
          idx = int'(m_addr) % DEPTH;
          if (m_we) begin mem[idx] = m_wd; mv[idx] = 1; end
          else begin m_rd = mem[idx]; m_rvalid = mv[idx]; end
        end else if (m_we) begin
`ifdef LC3_KBD_INT_EN
          if (m_addr == ADDR_KBSR) kb_ie = m_wd[14];
`endif
          if (m_addr == ADDR_DDR && !p_dv) begin dv = 1; dd = m_wd[7:0]; end
        end else begin
          if (m_addr == ADDR_KBSR) m_rd = {p_rdy, p_ie, 14'd0};
          else if (m_addr == ADDR_KBDR) begin m_rd = {8'h00, kb_dat}; clr = 1; end
          else if (m_addr == ADDR_DSR) m_rd = {!p_dv, 15'd0};
          else if (m_addr == ADDR_DDR) m_rd = {8'h00, dd};
        end
      end
      m_ack = 0;
      if (clr) kb_rdy = 0;
      else if (kb_valid && !p_rdy) begin kb_rdy = 1; kb_dat = kb_data; m_ack = 1; end
      if (p_dv && disp_ready) dv = 0;
      m_int = p_rdy && p_ie;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("r_bit", 16'(bus.r_bit), 16'(m_ready));
      chk("kb_ack", 16'(kb_ack), 16'(m_ack));
      chk("disp_valid", 16'(disp_valid), 16'(dv));
      chk("disp_data", 16'(disp_data), 16'(dd));
      chk("kb_int", 16'(kb_int), 16'(m_int));
      if (m_ready && !m_we && m_rvalid) chk("mem_data", bus.mem_data, m_rd);
    end
  end

  // Keyboard source: present queued chars, hold each until acknowledged.
  logic [7:0] kbq [$];
  always @(posedge clk) begin
    #1;
    if (kb_valid && kb_ack) begin
      void'(kbq.pop_front());
      kb_valid = 1'b0;
    end else if (!kb_valid && kbq.size() > 0) begin
      kb_valid = 1'b1;
      kb_data  = kbq[0];
    end
  end

  task automatic access(input bit we, input logic [15:0] addr, input logic [15:0] data,
                        input int abort_after, output logic [15:0] rd, output int lat);
    @(posedge clk); #1;
    bus.mio_en = 1'b1; bus.r_w = we; bus.mar = addr; bus.mdr = data;
    rd = 16'h0000; lat = 0;
    if (abort_after > 0) begin
      repeat (abort_after) @(posedge clk);
      #1 bus.mio_en = 1'b0;
    end else begin
      for (int n = 1; n <= 20; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.r_bit) begin
          lat = n;
          rd  = bus.mem_data;
          break;
        end
      end
      chk("latency", 16'(lat), 16'(WAIT_CYCLES + 1));
      @(posedge clk); #1;
      bus.mio_en = 1'b0;
    end
  endtask

  initial begin : main
    logic [15:0] rd, a, d;
    int lat, ab;
    bit we;
    bus.mio_en = 1'b0; bus.r_w = 1'b0; bus.mar = '0; bus.mdr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_r_bit", 16'(bus.r_bit), 16'h0000);
    chk("rst_mem_data", bus.mem_data, 16'h0000);
    chk("rst_disp_valid", 16'(disp_valid), 16'h0000);
    chk("rst_kb_int", 16'(kb_int), 16'h0000);

    // 1: write then read back
    access(1, 16'h3000, 16'h1234, 0, rd, lat);
    access(0, 16'h3000, 16'h0000, 0, rd, lat);
    chk("t1_read", rd, 16'h1234);

    // 2: aborted write leaves old value; aliasing
    access(1, 16'h3001, 16'h1111, 0, rd, lat);
    access(1, 16'h3001, 16'hBEEF, 2, rd, lat);
    access(0, 16'h3001, 16'h0000, 0, rd, lat);
    chk("t2_read_after_abort", rd, 16'h1111);
    access(0, 16'h4001, 16'h0000, 0, rd, lat);
    chk("t2_alias", rd, 16'h1111);

    // 3: keyboard capture, second char held until KBDR read
    kbq.push_back(8'h41);
    repeat (4) @(posedge clk);
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t3_kbsr_ready", rd, 16'h8000);
    kbq.push_back(8'h42);
    repeat (4) @(posedge clk);
    access(0, ADDR_KBDR, 16'h0000, 0, rd, lat);
    chk("t3_kbdr_first", rd, 16'h0041);
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t3_kbsr_second", rd, 16'h8000);
    access(0, ADDR_KBDR, 16'h0000, 0, rd, lat);
    chk("t3_kbdr_second", rd, 16'h0042);
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t3_kbsr_clear", rd, 16'h0000);

    // 4: display handshake, write while busy dropped
    access(1, ADDR_DDR, 16'h0058, 0, rd, lat);
    access(0, ADDR_DSR, 16'h0000, 0, rd, lat);
    chk("t4_dsr_busy", rd, 16'h0000);
    access(1, ADDR_DDR, 16'h0059, 0, rd, lat);
    chk("t4_disp_data", 16'(disp_data), 16'h0058);
    access(0, ADDR_DDR, 16'h0000, 0, rd, lat);
    chk("t4_ddr_read", rd, 16'h0058);
    disp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 disp_ready = 1'b0;
    access(0, ADDR_DSR, 16'h0000, 0, rd, lat);
    chk("t4_dsr_idle", rd, 16'h8000);

    // 5: keyboard interrupt
    access(1, ADDR_KBSR, 16'h4000, 0, rd, lat);
    kbq.push_back(8'h43);
    repeat (5) @(posedge clk);
`ifdef LC3_KBD_INT_EN
    @(negedge clk);
    chk("t5_kb_int_set", 16'(kb_int), 16'h0001);
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t5_kbsr", rd, 16'hC000);
    access(0, ADDR_KBDR, 16'h0000, 0, rd, lat);
    chk("t5_kbdr", rd, 16'h0043);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_kb_int_clear", 16'(kb_int), 16'h0000);
`else
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t5_kbsr", rd, 16'h8000);
    @(negedge clk);
    chk("t5_kb_int_off", 16'(kb_int), 16'h0000);
    access(0, ADDR_KBDR, 16'h0000, 0, rd, lat);
    chk("t5_kbdr", rd, 16'h0043);
`endif

    // 6: reset while READY with a pending display char
    access(1, ADDR_DDR, 16'h0061, 0, rd, lat);
    kbq.push_back(8'h44);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    bus.mio_en = 1'b1; bus.r_w = 1'b0; bus.mar = 16'h3000;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.r_bit) begin lat = n; break; end
    end
    chk("t6_reach_ready", 16'(lat), 16'(WAIT_CYCLES + 1));
    chk("t6_disp_pending", 16'(disp_valid), 16'h0001);
    rst = 1'b1; bus.mio_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_r_bit", 16'(bus.r_bit), 16'h0000);
    chk("t6_disp_valid", 16'(disp_valid), 16'h0000);
    rst = 1'b0;
    access(0, ADDR_KBSR, 16'h0000, 0, rd, lat);
    chk("t6_kbsr", rd, 16'h0000);
    access(0, 16'h3000, 16'h0000, 0, rd, lat);
    chk("t6_ram_kept", rd, 16'h1234);

    // Randomized accesses, checked by the per-cycle comparator.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: a = ADDR_KBSR;
        1: a = ADDR_KBDR;
        2: a = ADDR_DSR;
        3: a = ADDR_DDR;
        4: a = ($urandom_range(0, 1) == 1) ? 16'hFE08 : 16'hFFFE;
        default: a = 16'(16'h3000 + $urandom_range(0, 7) + (($urandom_range(0, 1) == 1) ? 16'h1000 : 16'h0000));
      endcase
      we = ($urandom_range(0, 1) == 1);
      d  = 16'($urandom);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WAIT_CYCLES)) : 0;
      disp_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0 && kbq.size() < 2) kbq.push_back(8'($urandom));
      access(we, a, d, ab, rd, lat);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
